// File: rtl/ram_port_arbiter.sv
// Arbiter for the shared single-port output RAM: CPU (rd/wr) vs readout unit (rd only),
// with an exclusive readout lock. Define ARB_ROUND_ROBIN_EN for round-robin sharing.
module ram_port_arbiter #(
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_rvalid,
  output logic [DW-1:0] rd_rdata,
  input  logic          lock_rd,
  output logic          locked,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {SHARED, DRAIN, LOCKED} state_t;

  state_t        state;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] rd_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_winner_rd;
`else
  localparam int           CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
  logic [CW-1:0] wait_cnt;
`endif

  // Grant decision. Anything other than plain SHARED sharing is readout-only.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    cpu_gnt = 1'b0;
    rd_gnt  = 1'b0;
    if (!reset) begin
      if (state != SHARED || lock_rd) begin
        rd_gnt = rd_req;
      end else if (cpu_req && rd_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        rd_gnt  = !last_winner_rd;
        cpu_gnt = last_winner_rd;
`else
        rd_gnt  = (wait_cnt == WAIT_MAX);
        cpu_gnt = !rd_gnt;
`endif
      end else begin
        cpu_gnt = cpu_req;
        rd_gnt  = rd_req;
      end
    end
  end

  assign ram_en    = cpu_gnt | rd_gnt;
  assign ram_we    = cpu_gnt & cpu_we;
  assign ram_addr  = cpu_gnt ? cpu_addr : (rd_gnt ? rd_addr : '0);
  assign ram_din   = cpu_gnt ? cpu_wdata : '0;

  // Returning port sees the RAM output directly; the other port keeps its last word.
  assign cpu_rdata = cpu_rvalid ? ram_dout : cpu_rdata_q;
  assign rd_rdata  = rd_rvalid  ? ram_dout : rd_rdata_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state       <= SHARED;
      locked      <= 1'b0;
      cpu_rvalid  <= 1'b0;
      rd_rvalid   <= 1'b0;
      cpu_rdata_q <= '0;
      rd_rdata_q  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      rd_rvalid  <= rd_gnt;
      if (cpu_rvalid) cpu_rdata_q <= ram_dout;
      if (rd_rvalid)  rd_rdata_q  <= ram_dout;
      case (state)
        SHARED:  if (lock_rd) state <= DRAIN;
        DRAIN:   state <= lock_rd ? LOCKED : SHARED;
        LOCKED:  if (!lock_rd) state <= SHARED;
        default: state <= SHARED;
      endcase
      locked <= lock_rd && (state == DRAIN || state == LOCKED);
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_rd <= 1'b0;
    end else if (cpu_gnt) begin
      last_winner_rd <= 1'b0;
    end else if (rd_gnt) begin
      last_winner_rd <= 1'b1;
    end
  end
`else
  // Starvation counter; frozen while the readout owns the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != LOCKED) begin
      if (!rd_req || rd_gnt) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural model plus directed and random stimulus.
module tb_ram_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int MAX_WAIT = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt, rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic          lock_rd = 1'b0;
  logic          locked;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid),
    .rd_rdata(rd_rdata), .lock_rd(lock_rd), .locked(locked),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // The RAM block itself: one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=sharing, 1=draining, 2=locked.
  logic [DW-1:0] exp_mem [DEPTH];
  int            m_phase = 0;
  int            m_starve = 0;
  bit            m_last_rd = 1'b0;
  bit            m_cpu_rv = 1'b0, m_rd_rv = 1'b0, m_locked = 1'b0;
  logic [DW-1:0] m_cpu_rdata = '0, m_rd_rdata = '0;
  bit            e_cpu, e_rd;

  always @(negedge clk) begin
    if (chk_en) begin
      e_cpu = 1'b0;
      e_rd  = 1'b0;
      if (!reset) begin
        if (m_phase != 0 || lock_rd) e_rd = rd_req;
        else if (cpu_req && rd_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          e_rd = !m_last_rd;
`else
          e_rd = (m_starve == MAX_WAIT);
`endif
          e_cpu = !e_rd;
        end else begin
          e_cpu = cpu_req;
          e_rd  = rd_req;
        end
      end
      check("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
      check("rd_gnt", 32'(rd_gnt), 32'(e_rd));
      check("ram_en", 32'(ram_en), 32'(e_cpu | e_rd));
      check("ram_we", 32'(ram_we), 32'(e_cpu & cpu_we));
      check("ram_addr", 32'(ram_addr), e_cpu ? 32'(cpu_addr) : (e_rd ? 32'(rd_addr) : 32'd0));
      check("ram_din", 32'(ram_din), e_cpu ? 32'(cpu_wdata) : 32'd0);
      check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv));
      check("rd_rvalid", 32'(rd_rvalid), 32'(m_rd_rv));
      check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
      check("rd_rdata", 32'(rd_rdata), 32'(m_rd_rdata));
      check("locked", 32'(locked), 32'(m_locked));
      // Advance the model to the state after the coming edge.
      if (reset) begin
        m_phase = 0; m_starve = 0; m_last_rd = 1'b0;
        m_cpu_rv = 1'b0; m_rd_rv = 1'b0; m_locked = 1'b0;
        m_cpu_rdata = '0; m_rd_rdata = '0;
      end else begin
        m_cpu_rv = e_cpu && !cpu_we;
        m_rd_rv  = e_rd;
        if (e_cpu && !cpu_we) m_cpu_rdata = exp_mem[cpu_addr];
        if (e_cpu && cpu_we)  exp_mem[cpu_addr] = cpu_wdata;
        if (e_rd)             m_rd_rdata = exp_mem[rd_addr];
        if (m_phase != 2) begin
          if (!rd_req || e_rd) m_starve = 0;
          else if (m_starve < MAX_WAIT) m_starve++;
        end
        if (e_cpu) m_last_rd = 1'b0;
        if (e_rd)  m_last_rd = 1'b1;
        m_phase  = lock_rd ? ((m_phase < 2) ? m_phase + 1 : 2) : 0;
        m_locked = (m_phase == 2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  n_cpu, n_rd, n_both, first_rd, n_rv;
  bit  g_cpu, g_rd;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'(16'h1000 + i);
      exp_mem[i] = DW'(16'h1000 + i);
    end
    ram_dout = '0;

    // Reset
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);

    // CPU write then read of address 5
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd5; cpu_wdata = 16'hA5A5;
    @(negedge clk);
    check("wr_gnt", 32'(cpu_gnt), 32'd1);
    check("wr_ram_we", 32'(ram_we), 32'd1);
    step();
    cpu_we = 1'b0;
    @(negedge clk);
    check("rdb_gnt", 32'(cpu_gnt), 32'd1);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check("rdb_rvalid", 32'(cpu_rvalid), 32'd1);
    check("rdb_rdata", 32'(cpu_rdata), 32'h0000A5A5);
    check("rdb_rd_rvalid", 32'(rd_rvalid), 32'd0);

    // Continuous contention
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5; rd_req = 1'b1; rd_addr = 6'd9;
    n_cpu = 0; n_rd = 0; n_both = 0; first_rd = -1;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      if (cpu_gnt && rd_gnt) n_both++;
      if (cpu_gnt) n_cpu++;
      if (rd_gnt) begin
        n_rd++;
        if (first_rd < 0) first_rd = c;
      end
      step();
    end
    cpu_req = 1'b0; rd_req = 1'b0;
    check("cont_both", 32'(n_both), 32'd0);
`ifdef ARB_ROUND_ROBIN_EN
    check("cont_first_rd", 32'(first_rd), 32'd0);
    check("cont_n_rd", 32'(n_rd), 32'd14);
    check("cont_n_cpu", 32'(n_cpu), 32'd13);
`else
    check("cont_first_rd", 32'(first_rd), 32'd8);
    check("cont_n_rd", 32'(n_rd), 32'd3);
    check("cont_n_cpu", 32'(n_cpu), 32'd24);
`endif

    // CPU read, then lock request while CPU keeps asking
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
    @(negedge clk);
    check("lk_cpu_gnt", 32'(cpu_gnt), 32'd1);
    step();
    lock_rd = 1'b1;
    @(negedge clk);
    check("lk_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("lk_cpu_rdata", 32'(cpu_rdata), 32'h0000A5A5);
    check("lk_req_nogrant", 32'(cpu_gnt), 32'd0);
    step();
    @(negedge clk);
    check("drain_nogrant", 32'(cpu_gnt), 32'd0);
    check("drain_locked", 32'(locked), 32'd0);
    step();
    n_cpu = 0; n_rd = 0; n_rv = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_req = 1'b1; rd_addr = AW'(i);
      @(negedge clk);
      if (i == 0) check("lk_locked", 32'(locked), 32'd1);
      if (rd_gnt) n_rd++;
      if (cpu_gnt) n_cpu++;
      if (rd_rvalid) n_rv++;
      step();
    end
    rd_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rd_rvalid) n_rv++;
      if (cpu_gnt) n_cpu++;
      step();
    end
    check("lk_rd_grants", 32'(n_rd), 32'd64);
    check("lk_rd_pulses", 32'(n_rv), 32'd64);
    check("lk_cpu_stalled", 32'(n_cpu), 32'd0);

    // Release lock with the CPU request still pending
    lock_rd = 1'b0;
    @(negedge clk);
    check("unlk_still_locked", 32'(locked), 32'd1);
    check("unlk_nogrant", 32'(cpu_gnt), 32'd0);
    step();
    @(negedge clk);
    check("unlk_locked", 32'(locked), 32'd0);
    check("unlk_cpu_gnt", 32'(cpu_gnt), 32'd1);
    step();
    cpu_req = 1'b0;

    // Reset right after a readout read grant
    rd_req = 1'b1; rd_addr = 6'd7;
    @(negedge clk);
    check("rst_pre_gnt", 32'(rd_gnt), 32'd1);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ram_en", 32'(ram_en), 32'd0);
    step();
    reset = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    check("rst_rd_rvalid", 32'(rd_rvalid), 32'd0);
    check("rst_locked2", 32'(locked), 32'd0);
    check("rst_ram_en2", 32'(ram_en), 32'd0);
    step();

    // Random traffic; requests are held until granted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g_cpu = cpu_gnt;
      g_rd  = rd_gnt;
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if (!cpu_req || g_cpu) begin
        cpu_req   = ($urandom_range(0, 9) < 8);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = AW'($urandom);
        cpu_wdata = DW'($urandom);
      end
      if (!rd_req || g_rd) begin
        rd_req  = ($urandom_range(0, 9) < 6);
        rd_addr = AW'($urandom);
      end
      if ($urandom_range(0, 49) == 0) lock_rd = !lock_rd;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
